conv3_window_mac: RTL and testbench

//  Downstream consumer of the three-row accelerator buffer (three parallel FIFOs, depth 3, shared read enable).

---
 rtl/conv3_window_mac_pkg.sv | 37 +++
 rtl/conv3_window_mac_if.sv | 40 ++++
 rtl/conv3_window_mac_mac3_col.sv | 33 +++
 rtl/conv3_window_mac.sv | 155 +++++++++++++++
 tb/tb_conv3_window_mac.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/conv3_window_mac_pkg.sv
// conv3_window_mac_pkg: shared state encoding, kernel geometry and saturation helper
// Revision: 1.0
`default_nettype none

package conv3_window_mac_pkg;

  localparam int KERNEL_N  = 3;
  localparam int KERNEL_SZ = KERNEL_N * KERNEL_N;
  // Wide enough to carry any accumulator this block can be built with
  localparam int SAT_W     = 128;
  localparam logic signed [SAT_W-1:0] SAT_ONE = SAT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_SAT   = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  function automatic logic signed [SAT_W-1:0] sat_to_out(
    input logic signed [SAT_W-1:0] v,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (SAT_ONE << (out_w - 1)) - SAT_ONE;
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv3_window_mac_if.sv
// conv3_window_mac_if: control, row-buffer, weight-bus and result signals of the window MAC
// Revision: 1.0
`default_nettype none

interface conv3_window_mac_if #(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32
);

  logic              start;
  logic [DATA_W-1:0] row_1;
  logic [DATA_W-1:0] row_2;
  logic [DATA_W-1:0] row_3;
  logic              buf_full;
  logic              buf_empty;
  logic              buf_rd_en;
  logic              w_we;
  logic [3:0]        w_addr;
  logic [DATA_W-1:0] w_data;
  logic [OUT_W-1:0]  res_data;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              err;

  modport slave (
    input  start, row_1, row_2, row_3, buf_full, buf_empty,
    input  w_we, w_addr, w_data, res_ready,
    output buf_rd_en, res_data, res_valid, busy, err
  );

  modport master (
    output start, row_1, row_2, row_3, buf_full, buf_empty,
    output w_we, w_addr, w_data, res_ready,
    input  buf_rd_en, res_data, res_valid, busy, err
  );

endinterface

`default_nettype wire

// File: rtl/conv3_window_mac_mac3_col.sv
// conv3_window_mac_mac3_col: one kernel column, three signed products summed at accumulator width
// Revision: 1.0
`default_nettype none

module conv3_window_mac_mac3_col #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2 * DATA_W + 4
) (
  input  logic signed [DATA_W-1:0] s0,
  input  logic signed [DATA_W-1:0] s1,
  input  logic signed [DATA_W-1:0] s2,
  input  logic signed [DATA_W-1:0] k0,
  input  logic signed [DATA_W-1:0] k1,
  input  logic signed [DATA_W-1:0] k2,
  output logic signed [ACC_W-1:0]  psum
);

  localparam int PW = 2 * DATA_W;

  logic signed [PW-1:0] p0;
  logic signed [PW-1:0] p1;
  logic signed [PW-1:0] p2;

  // Operands widened first so the full product is kept
  assign p0 = PW'(s0) * PW'(k0);
  assign p1 = PW'(s1) * PW'(k1);
  assign p2 = PW'(s2) * PW'(k2);

  assign psum = ACC_W'(p0) + ACC_W'(p1) + ACC_W'(p2);

endmodule

`default_nettype wire

// File: rtl/conv3_window_mac.sv
// conv3_window_mac: pops one 3x3 window from the three-row buffer, MACs it against a
// bus-loaded kernel and presents the saturated dot product on a valid/ready port. Revision: 1.0
`default_nettype none

module conv3_window_mac
  import conv3_window_mac_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int ACC_W  = 2 * DATA_W + 4
) (
  input logic               clk,
  input logic               reset,
  conv3_window_mac_if.slave bus
);

  state_t state;
  state_t state_nx;

  logic [1:0]               col;
  logic [1:0]               cap_col;
  logic                     cap_valid;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  psum;
  logic signed [DATA_W-1:0] w [KERNEL_SZ];

  logic rd_en;
  logic abort;
  logic clear;
  logic load_res;
  logic handshake;
  logic w_ok;
  logic mac_en;

  logic [3:0] idx_r1;
  logic [3:0] idx_r2;
  logic [3:0] idx_r3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    rd_en     = 1'b0;
    abort     = 1'b0;
    clear     = 1'b0;
    load_res  = 1'b0;
    handshake = 1'b0;
    w_ok      = 1'b0;
    case (state)
      S_IDLE: begin
        w_ok = 1'b1;
        if (bus.start) begin
          clear    = 1'b1;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        w_ok = 1'b1;
        if (bus.buf_full) state_nx = S_READ;
      end
      S_READ: begin
        // An underrun poisons the window: no pop, drop the partial sum
        if (bus.buf_empty) begin
          abort    = 1'b1;
          state_nx = S_IDLE;
        end else begin
          rd_en = 1'b1;
          if (col == 2'(KERNEL_N - 1)) state_nx = S_DRAIN;
        end
      end
      S_DRAIN: state_nx = S_SAT;
      S_SAT: begin
        w_ok     = 1'b1;
        load_res = 1'b1;
        state_nx = S_OUT;
      end
      S_OUT: begin
        w_ok = 1'b1;
        if (bus.res_ready) begin
          handshake = 1'b1;
          state_nx  = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FIFO data lags its pop by one cycle, so MAC the column popped last cycle
  assign mac_en = cap_valid && !abort && (state == S_READ || state == S_DRAIN);

  assign idx_r1 = {2'b00, cap_col};
  assign idx_r2 = idx_r1 + 4'd3;
  assign idx_r3 = idx_r1 + 4'd6;

  conv3_window_mac_mac3_col #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac3_col (
    .s0   (bus.row_1),
    .s1   (bus.row_2),
    .s2   (bus.row_3),
    .k0   (w[idx_r1]),
    .k1   (w[idx_r2]),
    .k2   (w[idx_r3]),
    .psum (psum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col           <= '0;
      cap_col       <= '0;
      cap_valid     <= 1'b0;
      acc           <= '0;
      bus.res_data  <= '0;
      bus.res_valid <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      cap_valid <= rd_en;
      cap_col   <= col;

      if (state == S_WAIT) col <= '0;
      else if (rd_en)      col <= col + 2'd1;

      if (clear || abort) acc <= '0;
      else if (mac_en)    acc <= acc + psum;

      if (clear)      bus.err <= 1'b0;
      else if (abort) bus.err <= 1'b1;

      if (load_res) begin
        bus.res_data  <= OUT_W'(sat_to_out(SAT_W'(acc), OUT_W));
        bus.res_valid <= 1'b1;
      end else if (handshake) begin
        bus.res_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < KERNEL_SZ; i++) w[i] <= '0;
    end else if (bus.w_we && w_ok && bus.w_addr < 4'(KERNEL_SZ)) begin
      w[bus.w_addr] <= bus.w_data;
    end
  end

  assign bus.buf_rd_en = rd_en;
  assign bus.busy      = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_conv3_window_mac.sv
// tb_conv3_window_mac: directed bench with a three-row FIFO model and a result scoreboard
// Revision: 1.0
`default_nettype none

module tb_conv3_window_mac;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  conv3_window_mac_if #(.DATA_W(32), .OUT_W(32)) bus ();

  conv3_window_mac #(.DATA_W(32), .OUT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] exp_q[$];
  logic [31:0] samp [3][3];
  logic [31:0] wm [9];
  logic        force_empty = 1'b0;
  logic        pop_pending = 1'b0;
  int          rd_count = 0;

  // Buffer model: pop on the edge after rd_en, data_out valid the cycle after
  always @(negedge clk) begin
    pop_pending = bus.buf_rd_en;
    if (bus.buf_rd_en === 1'b1) rd_count++;
  end

  always @(posedge clk) begin
    #1;
    if (pop_pending && q3.size() > 0) begin
      bus.row_1 = q1.pop_front();
      bus.row_2 = q2.pop_front();
      bus.row_3 = q3.pop_front();
    end
    bus.buf_full  = (q3.size() == 3);
    bus.buf_empty = (q3.size() == 0) || force_empty;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model();
    logic signed [127:0] s;
    logic signed [127:0] a;
    logic signed [127:0] b;
    s = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        a = 128'($signed(samp[r][c]));
        b = 128'($signed(wm[r*3+c]));
        s = s + a * b;
      end
    if (s > 128'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    if (s < -128'sh8000_0000) return 32'h8000_0000;
    return s[31:0];
  endfunction

  task automatic set_w(input int addr, input logic [31:0] data, input bit accept);
    @(negedge clk);
    bus.w_we   = 1'b1;
    bus.w_addr = 4'(addr);
    bus.w_data = data;
    @(negedge clk);
    bus.w_we = 1'b0;
    if (accept && addr < 9) wm[addr] = data;
  endtask

  task automatic set_all_w(input logic [31:0] data);
    for (int i = 0; i < 9; i++) set_w(i, data, 1'b1);
  endtask

  task automatic samples_seq();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) samp[r][c] = 32'(3 * c + r + 1);
  endtask

  task automatic samples_all(input logic [31:0] v);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) samp[r][c] = v;
  endtask

  task automatic fill(input bit expect_result);
    for (int c = 0; c < 3; c++) begin
      q1.push_back(samp[0][c]);
      q2.push_back(samp[1][c]);
      q3.push_back(samp[2][c]);
    end
    if (expect_result) exp_q.push_back(model());
  endtask

  task automatic flush();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // After fill: land in the WAIT cycle that first sees buf_full
  task automatic wait_full();
    @(posedge clk);
    #2;
  endtask

  task automatic collect(input string tag);
    int n;
    logic [31:0] e;
    n = 0;
    while (bus.res_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 64'(bus.res_valid), 64'(1));
    if (bus.res_valid === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, 64'(bus.res_data), 64'(e));
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(bus.res_valid), 64'(0));
    check({tag, "_idle"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    int base;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.w_we      = 1'b0;
    bus.w_addr    = '0;
    bus.w_data    = '0;
    bus.res_ready = 1'b0;
    for (int i = 0; i < 9; i++) wm[i] = '0;

    repeat (3) @(negedge clk);
    check("rst_valid", 64'(bus.res_valid), 64'(0));
    check("rst_data",  64'(bus.res_data),  64'(0));
    check("rst_busy",  64'(bus.busy),      64'(0));
    check("rst_err",   64'(bus.err),       64'(0));
    check("rst_rd_en", 64'(bus.buf_rd_en), 64'(0));
    reset = 1'b0;

    // Identity kernel, latency and pop count
    set_w(4, 32'd1, 1'b1);
    samples_seq();
    start_pulse();
    check("wait_busy", 64'(bus.busy), 64'(1));
    repeat (3) @(negedge clk);
    check("wait_no_rd", 64'(bus.buf_rd_en), 64'(0));
    fill(1'b1);
    wait_full();
    base = rd_count;
    repeat (5) @(posedge clk);
    #2;
    check("lat_early", 64'(bus.res_valid), 64'(0));
    @(posedge clk);
    #2;
    check("lat_edge", 64'(bus.res_valid), 64'(1));
    check("rd_pulses", 64'(rd_count - base), 64'(3));
    collect("identity");
    handshake("identity");

    // All-ones kernel with backpressure
    set_all_w(32'd1);
    start_pulse();
    fill(1'b1);
    collect("ones");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(bus.res_valid), 64'(1));
      check("hold_data",  64'(bus.res_data),  64'(45));
    end
    handshake("ones");

    // Saturation at both rails
    set_all_w(32'h7FFF_FFFF);
    samples_all(32'h7FFF_FFFF);
    start_pulse();
    fill(1'b1);
    collect("sat_pos");
    handshake("sat_pos");

    set_all_w(32'd1);
    samples_all(32'h8000_0000);
    start_pulse();
    fill(1'b1);
    collect("sat_neg");
    handshake("sat_neg");

    // Underrun on the second READ cycle
    samples_seq();
    start_pulse();
    fill(1'b0);
    wait_full();
    @(posedge clk);
    @(negedge clk);
    force_empty = 1'b1;
    @(negedge clk);
    check("abort_rd_en", 64'(bus.buf_rd_en), 64'(0));
    @(negedge clk);
    check("abort_err",   64'(bus.err),       64'(1));
    check("abort_busy",  64'(bus.busy),      64'(0));
    repeat (5) @(negedge clk);
    check("abort_no_res", 64'(bus.res_valid), 64'(0));
    force_empty = 1'b0;
    flush();
    start_pulse();
    check("err_cleared", 64'(bus.err), 64'(0));
    fill(1'b1);
    collect("after_abort");
    handshake("after_abort");

    // Weight writes: dropped in READ, ignored out of range, applied from OUT
    set_all_w(32'd0);
    set_w(4, 32'd1, 1'b1);
    set_w(12, 32'h77, 1'b0);
    start_pulse();
    fill(1'b1);
    wait_full();
    @(posedge clk);
    @(negedge clk);
    bus.w_we   = 1'b1;
    bus.w_addr = 4'd4;
    bus.w_data = 32'd100;
    @(negedge clk);
    bus.w_we = 1'b0;
    collect("rd_write_drop");
    set_w(4, 32'd100, 1'b1);
    handshake("rd_write_drop");
    start_pulse();
    fill(1'b1);
    collect("out_write");
    handshake("out_write");

    // Reset during DRAIN
    start_pulse();
    fill(1'b0);
    wait_full();
    repeat (4) @(posedge clk);
    #2;
    check("drain_busy", 64'(bus.busy), 64'(1));
    reset = 1'b1;
    #1;
    check("drain_rst_valid", 64'(bus.res_valid), 64'(0));
    check("drain_rst_data",  64'(bus.res_data),  64'(0));
    check("drain_rst_busy",  64'(bus.busy),      64'(0));
    check("drain_rst_err",   64'(bus.err),       64'(0));
    check("drain_rst_rd_en", 64'(bus.buf_rd_en), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    flush();
    for (int i = 0; i < 9; i++) wm[i] = '0;

    // Mixed-sign kernel and samples after the reset
    for (int i = 0; i < 9; i++) set_w(i, 32'(i - 4), 1'b1);
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) samp[r][c] = 32'((r * 3 + c - 4) * 1000 + 7);
    start_pulse();
    fill(1'b1);
    collect("signed_mix");
    handshake("signed_mix");

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
